// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the digit-serial adder:
//   - state_e      : sequencer states (IDLE / RUN / DONE)
//   - steps_of     : number of digit steps for a WIDTH/DIGIT pair
//   - params_ok    : legality of a WIDTH/DIGIT pair
//   - full_add     : the 1-bit full adder cell used as the per-bit slice
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Number of clock steps needed to consume a WIDTH-bit operand DIGIT bits
    // at a time; returns 0 for a zero digit so the legality check can reject it.
    function automatic int unsigned steps_of(input int unsigned w, input int unsigned d);
        int unsigned r;
        if (d == 32'd0) begin
            r = 32'd0;
        end else begin
            r = w / d;
        end
        return r;
    endfunction

    // A configuration is legal when both sizes are non-zero and the digit
    // divides the width exactly.
    function automatic logic params_ok(input int unsigned w, input int unsigned d);
        logic ok;
        if ((w >= 32'd1) && (d >= 32'd1) && (d <= w)) begin
            ok = ((w % d) == 32'd0);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // 1-bit full adder: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
        return {co, s};
    endfunction

endpackage

// File: rtl/serial_adder_ripple_digit.sv
// -----------------------------------------------------------------------------
// ripple_digit
// Combinational DIGIT-bit ripple-carry adder built from the 1-bit full adder
// cell, one cell per bit.
// Ports:
//   x, y : DIGIT-bit addends
//   ci   : carry into bit 0
//   s    : DIGIT-bit sum
//   co   : carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_digit
    import serial_adder_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign {c_s[i+1], s[i]} = full_add(x[i], y[i], c_s[i]);
    end

    assign co = c_s[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Multi-cycle adder computing a + b + cin over WIDTH bits, DIGIT bits per
// clock, with a registered carry between digits.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : operands present            in_ready : accepting (IDLE only)
//   a, b, cin : operands and carry-in
//   out_valid : result present              out_ready: consumer takes result
//   sum       : a+b+cin mod 2^WIDTH
//   cout      : unsigned carry-out
//   overflow  : two's-complement overflow
// sum/cout/overflow are registered and only change when a result completes,
// so they hold their last result outside DONE.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned STEPS = steps_of(WIDTH, DIGIT);
    localparam int unsigned CW    = (STEPS < 32'd1) ? 32'd1 : $clog2(STEPS + 32'd1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_e           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             carry_q,    carry_d;
    logic [WIDTH-1:0] a_sh_q,     a_sh_d;
    logic [WIDTH-1:0] b_sh_q,     b_sh_d;
    logic [WIDTH-1:0] sum_sh_q,   sum_sh_d;
    logic             a_msb_q,    a_msb_d;
    logic             b_msb_q,    b_msb_d;
    logic [WIDTH-1:0] sum_q,      sum_d;
    logic             cout_q,     cout_d;
    logic             ovf_q,      ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_c_s;
    logic [WIDTH-1:0] sum_next_s;

    ripple_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x  (a_sh_q[DIGIT-1:0]),
        .y  (b_sh_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_c_s)
    );

    // New digit enters at the top while the partial sum shifts down; after
    // STEPS shifts the first digit has landed in bits [DIGIT-1:0].
    assign sum_next_s = (sum_sh_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // Sequencer: next-state, datapath updates and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = cin;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                carry_d  = dig_c_s;
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                sum_sh_d = sum_next_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 32'd1)) begin
                    // Last digit: publish the result in the same edge so
                    // out_valid rises exactly STEPS edges after acceptance.
                    state_d     = DONE;
                    sum_d       = sum_next_s;
                    cout_d      = dig_c_s;
                    ovf_d       = (a_msb_q == b_msb_q) && (dig_s[DIGIT-1] != a_msb_q);
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed, table-driven bench for serial_adder: an 8-bit/1-bit-digit unit and
// a 16-bit/4-bit-digit unit share clock and reset.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit, 1 bit per cycle
    logic       iv8, or8, cin8;
    logic [7:0] a8, b8;
    logic       ir8, ov8, co8, of8;
    logic [7:0] s8;

    // 16-bit, 4 bits per cycle
    logic        iv16, or16, cin16;
    logic [15:0] a16, b16;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .overflow(of8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .overflow(of16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec8_t;

    vec8_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Submit one 8-bit operation and wait (bounded) for its result.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] s, output logic co, output logic ovf,
                       output int lat);
        @(negedge clk);
        chk("in_ready8_before_accept", 32'(ir8), 32'd1);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov8 && lat < 40);
        chk("out_valid8_rises", 32'(ov8), 32'd1);
        s = s8; co = co8; ovf = of8;
    endtask

    // Hand the 8-bit result to the consumer and check return to IDLE.
    task automatic rel8();
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        chk("out_valid8_drops", 32'(ov8), 32'd0);
        chk("in_ready8_after_release", 32'(ir8), 32'd1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output logic ovf,
                        output int lat);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
        @(posedge clk);
        #1 iv16 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov16 && lat < 40);
        s = s16; co = co16; ovf = of16;
    endtask

    task automatic rel16();
        or16 = 1'b1;
        @(posedge clk);
        #1 or16 = 1'b0;
        chk("out_valid16_drops", 32'(ov16), 32'd0);
        chk("in_ready16_after_release", 32'(ir16), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rs8;
        logic [15:0] rs16;
        logic        rco, rovf;
        int          lat;
        logic [16:0] full;
        logic [15:0] ra, rb;
        logic        rc, eovf;

        vecs[0] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, sum: 8'h4B, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h7F, cin: 1'b1, sum: 8'hFF, cout: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};

        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("reset_out_valid", 32'(ov8), 32'd0);
        chk("reset_sum", 32'(s8), 32'd0);
        chk("reset_cout", 32'(co8), 32'd0);
        chk("reset_overflow", 32'(of8), 32'd0);
        chk("reset_in_ready", 32'(ir8), 32'd1);
        chk("reset_in_ready16", 32'(ir16), 32'd1);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, rs8, rco, rovf, lat);
            chk($sformatf("vec%0d_sum", i), 32'(rs8), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(rco), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_overflow", i), 32'(rovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            rel8();
        end

        // Backpressure: result must hold while the consumer stalls
        op8(8'h3C, 8'h0F, 1'b0, rs8, rco, rovf, lat);
        chk("bp_sum_initial", 32'(rs8), 32'h4B);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv8 = ~iv8;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            @(posedge clk);
            #1;
            chk("bp_sum_hold", 32'(s8), 32'h4B);
            chk("bp_cout_hold", 32'(co8), 32'd0);
            chk("bp_overflow_hold", 32'(of8), 32'd0);
            chk("bp_out_valid_hold", 32'(ov8), 32'd1);
            chk("bp_in_ready_low", 32'(ir8), 32'd0);
        end
        @(negedge clk);
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        chk("bp_release_out_valid", 32'(ov8), 32'd0);
        chk("bp_release_in_ready", 32'(ir8), 32'd1);

        // Reset in the middle of a run discards the operation and its carry
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midreset_out_valid", 32'(ov8), 32'd0);
        chk("midreset_sum", 32'(s8), 32'd0);
        chk("midreset_cout", 32'(co8), 32'd0);
        chk("midreset_in_ready", 32'(ir8), 32'd1);
        op8(8'h01, 8'h01, 1'b0, rs8, rco, rovf, lat);
        chk("post_reset_sum", 32'(rs8), 32'h02);
        chk("post_reset_cout", 32'(rco), 32'd0);
        chk("post_reset_latency", 32'(lat), 32'd8);
        rel8();

        // 16-bit, 4 bits per step: wrap case
        op16(16'hFFFF, 16'h0001, 1'b0, rs16, rco, rovf, lat);
        chk("w16_wrap_sum", 32'(rs16), 32'h0000);
        chk("w16_wrap_cout", 32'(rco), 32'd1);
        chk("w16_wrap_overflow", 32'(rovf), 32'd0);
        chk("w16_wrap_latency", 32'(lat), 32'd4);
        rel16();

        // Random back-to-back operations against a behavioural model
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            eovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            op16(ra, rb, rc, rs16, rco, rovf, lat);
            chk($sformatf("rand16_%0d a=%h b=%h c=%0d {lat,sum,cout,ovf}", i, ra, rb, rc),
                {12'h000, lat[3:0], rs16, rco, rovf} >> 0,
                {12'h000, 4'd4, full[15:0], full[16], eovf} >> 0);
            rel16();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
